// File: rtl/cola_morse.sv
// Character FIFO plus Morse encoder: queues 4-bit digit codes and hands one
// 10-bit dot/dash pattern downstream per `continue`, with a one-cycle load strobe.
module cola_morse #(
    parameter int PROF = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   wr_i,
    input  logic [3:0]             dato_i,
    input  logic                   continue_i,
    output logic [9:0]             morse_o,
    output logic                   audioreg_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(PROF):0]  count_o,
    output logic                   overflow_o
);

    localparam int AW = $clog2(PROF);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        EMITE   = 2'd1,
        OCUPADO = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      mem_q [PROF];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      morse_q;
    logic            audioreg_q;
    logic            overflow_q;
    logic            pop, push, full, empty;

    // dot = 2'b10, dash = 2'b11, first symbol in the MSBs; codes above 9 are silence.
    function automatic logic [9:0] encode(input logic [3:0] code);
        case (code)
            4'd0:    encode = 10'b11_11_11_11_11;
            4'd1:    encode = 10'b10_11_11_11_11;
            4'd2:    encode = 10'b10_10_11_11_11;
            4'd3:    encode = 10'b10_10_10_11_11;
            4'd4:    encode = 10'b10_10_10_10_11;
            4'd5:    encode = 10'b10_10_10_10_10;
            4'd6:    encode = 10'b11_10_10_10_10;
            4'd7:    encode = 10'b11_11_10_10_10;
            4'd8:    encode = 10'b11_11_11_10_10;
            4'd9:    encode = 10'b11_11_11_11_10;
            default: encode = 10'b00_00_00_00_00;
        endcase
    endfunction

    assign full  = (count_q == CW'(PROF));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same edge, so a full FIFO still accepts that push.
    assign push = wr_i && (!full || pop);

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            LIBRE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EMITE;
                end
            end
            EMITE:   state_d = continue_i ? LIBRE : OCUPADO;
            OCUPADO: if (continue_i) state_d = LIBRE;
            default: state_d = LIBRE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= LIBRE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            morse_q    <= '0;
            audioreg_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            audioreg_q <= pop;
            if (pop) begin
                morse_q  <= encode(mem_q[rd_ptr_q]);
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (wr_i && !push) overflow_q <= 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= dato_i;
    end

    assign morse_o    = morse_q;
    assign audioreg_o = audioreg_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
